// File: rtl/gcd_method_unit.sv
// Method-call responder computing gcd(a, b) by repeated subtraction, one step per clock.
// Result and step count are published on the edge where gcd_busy falls.
module gcd_method_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] gcd_a,
    input  logic [WIDTH-1:0] gcd_b,
    input  logic             gcd_req,
    output logic             gcd_busy,
    output logic [WIDTH-1:0] gcd_return,
    output logic [WIDTH-1:0] gcd_steps
);

    typedef enum logic {IDLE, CALC} state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            gcd_busy   <= 1'b0;
            gcd_return <= ZERO;
            gcd_steps  <= ZERO;
            x          <= ZERO;
            y          <= ZERO;
            cnt        <= ZERO;
        end else begin
            case (state)
                IDLE: begin
                    if (gcd_req) begin
                        x        <= gcd_a;
                        y        <= gcd_b;
                        cnt      <= ZERO;
                        gcd_busy <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    // Termination tests precede subtraction so zero operands finish in one cycle.
                    if (x == ZERO) begin
                        gcd_return <= y;
                        gcd_steps  <= cnt;
                        gcd_busy   <= 1'b0;
                        state      <= IDLE;
                    end else if (y == ZERO || x == y) begin
                        gcd_return <= x;
                        gcd_steps  <= cnt;
                        gcd_busy   <= 1'b0;
                        state      <= IDLE;
                    end else if (x > y) begin
                        x   <= x - y;
                        cnt <= cnt + ONE;
                    end else begin
                        y   <= y - x;
                        cnt <= cnt + ONE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    gcd_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_method_unit.sv
// Directed bench for gcd_method_unit at WIDTH=8: call latency, results, step counts,
// back-to-back calls with held request, and reset abort.
module tb_gcd_method_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] gcd_a;
    logic [7:0] gcd_b;
    logic       gcd_req;
    logic       gcd_busy;
    logic [7:0] gcd_return;
    logic [7:0] gcd_steps;

    int total = 0;
    int bad   = 0;
    logic [7:0] last_ret = 8'd0;

    gcd_method_unit #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .gcd_a      (gcd_a),
        .gcd_b      (gcd_b),
        .gcd_req    (gcd_req),
        .gcd_busy   (gcd_busy),
        .gcd_return (gcd_return),
        .gcd_steps  (gcd_steps)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Count busy cycles until gcd_busy drops; bounded so a stuck unit still reaches the summary.
    task automatic wait_done(inout int cyc);
        while (gcd_busy && cyc < 1000) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic run_call(input logic [7:0] a, input logic [7:0] b, input int exp_cyc,
                            input logic [7:0] exp_ret, input logic [7:0] exp_steps);
        int cyc;
        @(negedge clk);
        gcd_a = a; gcd_b = b; gcd_req = 1'b1;
        @(posedge clk);
        #1 gcd_req = 1'b0;
        cyc = 0;
        @(negedge clk);
        chk("busy_rise", int'(gcd_busy), 1);
        chk("ret_hold", int'(gcd_return), int'(last_ret));
        wait_done(cyc);
        chk("busy_cycles", cyc, exp_cyc);
        chk("result", int'(gcd_return), int'(exp_ret));
        chk("steps", int'(gcd_steps), int'(exp_steps));
        last_ret = exp_ret;
    endtask

    initial begin
        int cyc;
        reset = 1'b1; gcd_req = 1'b0; gcd_a = 8'd0; gcd_b = 8'd0;
        repeat (6) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_busy", int'(gcd_busy), 0);
            chk("rst_ret", int'(gcd_return), 0);
            chk("rst_steps", int'(gcd_steps), 0);
        end

        run_call(8'd12, 8'd18, 3, 8'd6, 8'd2);
        run_call(8'd48, 8'd18, 5, 8'd6, 8'd4);
        run_call(8'd17, 8'd5,  7, 8'd1, 8'd6);
        run_call(8'd0,  8'd7,  1, 8'd7, 8'd0);
        run_call(8'd9,  8'd0,  1, 8'd9, 8'd0);
        run_call(8'd0,  8'd0,  1, 8'd0, 8'd0);
        run_call(8'd21, 8'd21, 1, 8'd21, 8'd0);

        // Held request: operands change right after accept, must not affect the first call.
        @(negedge clk);
        gcd_a = 8'd48; gcd_b = 8'd18; gcd_req = 1'b1;
        @(posedge clk);
        #1 gcd_a = 8'd100; gcd_b = 8'd75;
        cyc = 0;
        @(negedge clk);
        wait_done(cyc);
        chk("held1_cycles", cyc, 5);
        chk("held1_result", int'(gcd_return), 6);
        chk("held1_steps", int'(gcd_steps), 4);
        @(negedge clk);
        chk("held_gap", int'(gcd_busy), 1);
        gcd_req = 1'b0;
        chk("held2_hold", int'(gcd_return), 6);
        cyc = 1;
        @(negedge clk);
        wait_done(cyc);
        chk("held2_cycles", cyc, 4);
        chk("held2_result", int'(gcd_return), 25);
        chk("held2_steps", int'(gcd_steps), 3);
        last_ret = 8'd25;

        run_call(8'd255, 8'd1, 255, 8'd1, 8'd254);

        // Reset two cycles into a long call aborts it without writing a result.
        @(negedge clk);
        gcd_a = 8'd255; gcd_b = 8'd1; gcd_req = 1'b1;
        @(posedge clk);
        #1 gcd_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(gcd_busy), 0);
        chk("abort_ret", int'(gcd_return), 0);
        chk("abort_steps", int'(gcd_steps), 0);
        last_ret = 8'd0;
        run_call(8'd12, 8'd18, 3, 8'd6, 8'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
